instr_feeder: RTL and testbench

Program-buffer and instruction-issue stage that sits directly upstream of the processor. It captures a program word-by-word from the board switches and then issues the words to the processor's data input in order, under a run/done handshake. It also supplies a program counter that the top level can show on the spare HEX digits.

---
 rtl/instr_feeder.sv | 133 +++++++++++++
 tb/tb_instr_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - program buffer and instruction issue stage; FEEDER_LOOP_EN repeats the program forever
module instr_feeder #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [15:0]   load_data_i,
    input  logic          clear_i,
    input  logic          start_i,
    output logic [15:0]   din_o,
    output logic          run_o,
    input  logic          next_i,
    input  logic          done_i,
    output logic [AW-1:0] pc_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          busy_o,
    output logic          halted_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   count_q;
    logic [15:0]   din_q;
    logic          run_q;
    logic          pend_q;     // a next-word read is due on the coming edge
    logic [15:0]   mem_q [DEPTH];

    logic          full;
    logic          loadable;
    logic          mem_we;
    logic [AW:0]   pc_inc;
    logic          has_more;

    assign full     = (count_q == DEPTH_CNT);
    assign loadable = (state_q == IDLE) || (state_q == HALT);
    // clear beats load, and a full buffer silently drops the word
    assign mem_we   = loadable && load_i && !clear_i && !full;
    assign pc_inc   = {1'b0, pc_q} + 1'b1;
    assign has_more = (pc_inc < count_q);

    // program RAM write port; contents survive reset and clear
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[count_q[AW-1:0]] <= load_data_i;
        end
    end

    // issue FSM with registered din/run; the RAM read register doubles as din
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            count_q <= '0;
            din_q   <= '0;
            run_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            run_q <= 1'b0;
            case (state_q)
                IDLE, HALT: begin
                    pend_q <= 1'b0;
                    if (clear_i) begin
                        count_q <= '0;
                    end else if (load_i && !full) begin
                        count_q <= count_q + 1'b1;
                    end
                    if (start_i) begin
                        if (count_q != '0) begin
                            pc_q    <= '0;
                            state_q <= FETCH;
                        end else begin
                            state_q <= HALT;
                        end
                    end
                end
                FETCH: begin
                    din_q   <= mem_q[pc_q];
                    run_q   <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    pend_q <= 1'b0;
                    if (done_i) begin
                        if (has_more) begin
                            pc_q    <= pc_inc[AW-1:0];
                            state_q <= FETCH;
                        end else begin
`ifdef FEEDER_LOOP_EN
                            pc_q    <= '0;
                            state_q <= FETCH;
`else
                            state_q <= HALT;
`endif
                        end
                    end else if (pend_q) begin
                        din_q <= mem_q[pc_q];
                    end else if (next_i && has_more) begin
                        pc_q   <= pc_inc[AW-1:0];
                        pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign din_o    = din_q;
    assign run_o    = run_q;
    assign pc_o     = pc_q;
    assign count_o  = count_q;
    assign full_o   = full;
    assign busy_o   = (state_q == FETCH) || (state_q == ISSUE) || (state_q == WAIT);
    assign halted_o = (state_q == HALT);

endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - directed self-checking bench for instr_feeder
module tb_instr_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_data = '0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        next = 1'b0;
    logic        done = 1'b0;
    logic [15:0] din;
    logic        run;
    logic [4:0]  pc;
    logic [5:0]  count;
    logic        full;
    logic        busy;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ld;
        logic        clr;
        logic [15:0] data;
        logic [5:0]  exp_count;
        logic        exp_full;
    } vec_t;

    vec_t tbl [8];

    instr_feeder #(.DEPTH(32), .AW(5)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .load_i      (load),
        .load_data_i (load_data),
        .clear_i     (clear),
        .start_i     (start),
        .din_o       (din),
        .run_o       (run),
        .next_i      (next),
        .done_i      (done),
        .pc_o        (pc),
        .count_o     (count),
        .full_o      (full),
        .busy_o      (busy),
        .halted_o    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d);
        load = 1'b1;
        load_data = d;
        step();
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'hAAAA, 6'd1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'hBBBB, 6'd2, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'hCCCC, 6'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 6'd0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 16'h1234, 6'd1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'h0042, 6'd2, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 16'h2000, 6'd3, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 16'h0000, 6'd3, 1'b0};
        tbl[7].clr = 1'b0;

        // reset values
        #2;
        check("rst_din", din, 0);
        check("rst_run", run, 0);
        check("rst_pc", pc, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        step();
        rst_n = 1'b1;
        step();

        // load/clear table
        for (int i = 0; i < 8; i++) begin
            load = tbl[i].ld;
            clear = tbl[i].clr;
            load_data = tbl[i].data;
            step();
            load = 1'b0;
            clear = 1'b0;
            check($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
            check($sformatf("tbl%0d_full", i), full, tbl[i].exp_full);
        end

        // start -> run two cycles later
        start = 1'b1;
        step();
        start = 1'b0;
        check("fetch_run", run, 0);
        check("fetch_busy", busy, 1);
        step();
        check("issue0_run", run, 1);
        check("issue0_din", din, 16'h1234);
        check("issue0_pc", pc, 0);
        step();
        check("wait0_run", run, 0);

        // next handshake: new din after two cycles, no run
        next = 1'b1;
        step();
        next = 1'b0;
        check("next_pc", pc, 1);
        check("next_din_hold", din, 16'h1234);
        check("next_run_a", run, 0);
        step();
        check("next_din", din, 16'h0042);
        check("next_run_b", run, 0);

        // done -> run with word 2
        done = 1'b1;
        step();
        done = 1'b0;
        check("done1_run", run, 0);
        step();
        check("issue2_run", run, 1);
        check("issue2_din", din, 16'h2000);
        check("issue2_pc", pc, 2);
        step();

        // next on last word is ignored
        next = 1'b1;
        step();
        next = 1'b0;
        step();
        check("lastnext_pc", pc, 2);
        check("lastnext_din", din, 16'h2000);

        // last done
        done = 1'b1;
        step();
        done = 1'b0;
`ifdef FEEDER_LOOP_EN
        check("loop_halted", halted, 0);
        check("loop_pc", pc, 0);
        step();
        check("loop_run", run, 1);
        check("loop_din", din, 16'h1234);
        check("loop_halted2", halted, 0);
`else
        check("end_halted", halted, 1);
        check("end_busy", busy, 0);
        step();
        check("end_run", run, 0);
`endif

        // done+next together, ignored load/clear in WAIT
        do_reset();
        do_load(16'h1234);
        do_load(16'h0042);
        do_load(16'h2000);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        do_load(16'hBEEF);
        check("wait_load_count", count, 3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("wait_clear_count", count, 3);
        check("wait_busy", busy, 1);
        done = 1'b1;
        next = 1'b1;
        step();
        done = 1'b0;
        next = 1'b0;
        check("dn_pc", pc, 1);
        step();
        check("dn_run", run, 1);
        check("dn_din", din, 16'h0042);
        step();

        // asynchronous reset mid-WAIT
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_din", din, 0);
        check("arst_pc", pc, 0);
        check("arst_count", count, 0);
        check("arst_busy", busy, 0);
        check("arst_run", run, 0);
        step();
        rst_n = 1'b1;
        step();

        // empty start -> HALT, no run
        start = 1'b1;
        step();
        start = 1'b0;
        check("empty_halted", halted, 1);
        check("empty_busy", busy, 0);
        check("empty_run_a", run, 0);
        step();
        check("empty_run_b", run, 0);

        // fill to DEPTH, then overflow load
        for (int i = 0; i < 32; i++) begin
            do_load(16'h0100 + 16'(i));
        end
        check("fill_count", count, 32);
        check("fill_full", full, 1);
        do_load(16'hFFFF);
        check("ovf_count", count, 32);
        check("ovf_full", full, 1);

        // restart from HALT and walk to the last word with next
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_halted", halted, 0);
        step();
        check("restart_run", run, 1);
        check("restart_din", din, 16'h0100);
        step();
        for (int i = 0; i < 31; i++) begin
            next = 1'b1;
            step();
            next = 1'b0;
            step();
        end
        check("walk_pc", pc, 31);
        check("walk_din31", din, 16'h011F);
        next = 1'b1;
        step();
        next = 1'b0;
        step();
        check("walk_last_pc", pc, 31);
        check("walk_last_din", din, 16'h011F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
